// File: rtl/hazard_scoreboard_unit.sv
// Per-register countdown scoreboard for the ID stage: RAW/WAW stall and issue
// generation with class-dependent latencies, branch-flush priority and a stall counter.

module hazard_sb_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic [2:0] cnt
);
    // An issuing writer's reload wins over the per-cycle decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - 3'd1;
    end
endmodule

module hazard_scoreboard_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 3,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_AW-1:0]    id_rs1_addr,
    input  logic                 id_rs1_used,
    input  logic [REG_AW-1:0]    id_rs2_addr,
    input  logic                 id_rs2_used,
    input  logic [REG_AW-1:0]    id_rd_addr,
    input  logic                 id_reg_write,
    input  logic [1:0]           id_class,
    input  logic                 ex_flush,
    output logic                 stall,
    output logic                 issue,
    output logic [2**REG_AW-1:0] busy_vec,
    output logic [CNT_W-1:0]     stall_count
);
    localparam int NREG = 2**REG_AW;

    logic [NREG-1:0][2:0] cnt;
    logic [NREG-1:0]      ld_vec;
    logic [2:0]           id_lat;
    logic                 raw1, raw2, waw;

    always_comb begin
        id_lat = 3'd0;
        case (id_class)
            2'b01:   id_lat = 3'(LOAD_LAT);
            2'b10:   id_lat = 3'(MUL_LAT);
            default: id_lat = 3'd0;
        endcase
    end

    // x0 terms are suppressed explicitly; cnt[0] is tied off as well.
    assign raw1 = id_rs1_used  && (id_rs1_addr != '0) && (cnt[id_rs1_addr] != 3'd0);
    assign raw2 = id_rs2_used  && (id_rs2_addr != '0) && (cnt[id_rs2_addr] != 3'd0);
    assign waw  = id_reg_write && (id_rd_addr  != '0) && (cnt[id_rd_addr] > id_lat);

    assign stall = !reset && id_valid && !ex_flush && (raw1 || raw2 || waw);
    assign issue = !reset && id_valid && !ex_flush && !stall;

    always_comb begin
        ld_vec = '0;
        if (issue && id_reg_write)
            ld_vec[id_rd_addr] = 1'b1;
    end

    genvar r;
    generate
        for (r = 0; r < NREG; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign cnt[r] = 3'd0;
            end else begin : g_cnt
                hazard_sb_cnt u_cnt (
                    .clk      (clk),
                    .reset    (reset),
                    .load     (ld_vec[r]),
                    .load_val (id_lat),
                    .cnt      (cnt[r])
                );
            end
            assign busy_vec[r] = (cnt[r] != 3'd0);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit; CNT_W is shrunk so saturation is reachable.

module tb_hazard_scoreboard_unit;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 id_valid;
    logic [REG_AW-1:0]    id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic                 id_rs1_used, id_rs2_used, id_reg_write;
    logic [1:0]           id_class;
    logic                 ex_flush;
    logic                 stall, issue;
    logic [2**REG_AW-1:0] busy_vec;
    logic [CNT_W-1:0]     stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] ALU = 2'b00, LD = 2'b01, MUL = 2'b10;

    hazard_scoreboard_unit #(.REG_AW(REG_AW), .LOAD_LAT(1), .MUL_LAT(3), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs2_used  (id_rs2_used),
        .id_rd_addr   (id_rd_addr),
        .id_reg_write (id_reg_write),
        .id_class     (id_class),
        .ex_flush     (ex_flush),
        .stall        (stall),
        .issue        (issue),
        .busy_vec     (busy_vec),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic rw,
                         input logic [1:0] cls, input logic fl);
        id_valid = v; id_rs1_addr = rs1; id_rs1_used = u1;
        id_rs2_addr = rs2; id_rs2_used = u2;
        id_rd_addr = rd; id_reg_write = rw; id_class = cls; ex_flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sc(input string tag, input logic s, input logic i);
        check({tag, ".stall"}, 32'(stall), 32'(s));
        check({tag, ".issue"}, 32'(issue), 32'(i));
    endtask

    initial begin
        reset = 1'b1;
        // Would issue if not held in reset.
        drive(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, ALU, 0);
        sc("rst", 0, 0);
        check("rst.busy", busy_vec, 32'h0);
        check("rst.cnt", 32'(stall_count), 32'd0);
        tick();
        reset = 1'b0;
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, ALU, 0);
        tick();

        // Load-use: LOAD x1 then consumer rs1=x1, rs2=x2
        drive(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, LD, 0);
        sc("ld.iss", 0, 1);
        tick();
        drive(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, ALU, 0);
        sc("lu.c1", 1, 0);
        check("lu.busy1", 32'(busy_vec[1]), 32'd1);
        tick();
        sc("lu.c2", 0, 1);
        check("lu.cnt", 32'(stall_count), 32'd1);
        tick();
        drive(1, 5'd0, 0, 5'd2, 1, 5'd0, 0, ALU, 0);
        sc("rs2.free", 0, 1);
        drive(0, 5'd1, 1, 5'd0, 0, 5'd0, 0, ALU, 0);
        sc("novalid", 0, 0);
        tick();

        // MUL x5 then consumer rs2=x5: 3 stalls, busy 1,1,1,0
        drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, MUL, 0);
        sc("mul.iss", 0, 1);
        tick();
        drive(1, 5'd0, 0, 5'd5, 1, 5'd0, 0, ALU, 0);
        for (int k = 0; k < 3; k++) begin
            sc($sformatf("mul.s%0d", k), 1, 0);
            check($sformatf("mul.b%0d", k), 32'(busy_vec[5]), 32'd1);
            tick();
        end
        sc("mul.go", 0, 1);
        check("mul.b3", 32'(busy_vec[5]), 32'd0);
        check("mul.cnt", 32'(stall_count), 32'd4);
        tick();

        // x0 never becomes busy
        drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, LD, 0);
        sc("x0.ld", 0, 1);
        tick();
        drive(1, 5'd0, 1, 5'd0, 0, 5'd0, 0, ALU, 0);
        sc("x0.use", 0, 1);
        check("x0.busy", 32'(busy_vec[0]), 32'd0);
        tick();

        // WAW: MUL x3 then ALU writes x3
        drive(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, MUL, 0);
        tick();
        drive(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, ALU, 0);
        for (int k = 0; k < 3; k++) begin
            sc($sformatf("waw.s%0d", k), 1, 0);
            tick();
        end
        sc("waw.go", 0, 1);
        tick();
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, ALU, 0);
        check("waw.busy", 32'(busy_vec[3]), 32'd0);
        check("waw.cnt", 32'(stall_count), 32'd7);

        // Flush kills the consumer of x7
        drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, LD, 0);
        tick();
        drive(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, LD, 1);
        sc("fl", 0, 0);
        check("fl.busy7", 32'(busy_vec[7]), 32'd1);
        tick();
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, ALU, 0);
        check("fl.busy7b", 32'(busy_vec[7]), 32'd0);
        check("fl.busy8", 32'(busy_vec[8]), 32'd0);
        check("fl.cnt", 32'(stall_count), 32'd7);

        // Asynchronous reset mid-stall with cnt[5] = 2
        drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, MUL, 0);
        tick();
        drive(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, ALU, 0);
        tick();
        sc("mid.pre", 1, 0);
        check("mid.cnt", 32'(stall_count), 32'd8);
        #2 reset = 1'b1;
        #1;
        sc("mid.rst", 0, 0);
        check("mid.busy", busy_vec, 32'h0);
        check("mid.sc", 32'(stall_count), 32'd0);
        #1 reset = 1'b0;
        #1;
        sc("mid.rel", 0, 1);
        tick();

        // Saturation of the 4-bit counter: 3 stalls per round
        for (int r = 0; r < 6; r++) begin
            drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, MUL, 0);
            tick();
            drive(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, ALU, 0);
            repeat (4) tick();
            if (r == 3) check("sat.12", 32'(stall_count), 32'd12);
            if (r == 4) check("sat.15", 32'(stall_count), 32'd15);
        end
        check("sat.hold", 32'(stall_count), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
